shift_job_scheduler: RTL and testbench
======================================

# shift_job_scheduler

Sequencer and 2-way arbiter for a shared SIZE-bit bidirectional shift register. Two requesters each submit a shift job (direction, bit count, serial pattern) over a valid/ready handshake. The scheduler grants one requester round-robin, clears the register, feeds it `count` serial bits, and returns the parallel result with the winner's id. It sits between the requesting blocks and the shift register's clk/reset/enable/direction/data_in/out pins.

## Interface
- SIZE, 8, shift register width (≥2)
- CNT_W, $clog2(SIZE+1), width of each count field
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  2  job request per requester (bit i = requester i)
- req_ready  out  2  one-cycle grant/accept pulse per requester
- req_dir  in  2  per-requester direction: 0 = shift left, 1 = shift right
- req_count  in  2*CNT_W  per-requester bit count; slice i = [i*CNT_W +: CNT_W]
- req_pattern  in  2*SIZE  per-requester serial pattern; slice i = [i*SIZE +: SIZE]
- sr_reset_n  out  1  synchronous active-low clear to the shift register
- sr_enable  out  1  shift enable
- sr_direction  out  1  shift direction
- sr_data_in  out  1  serial bit
- sr_out  in  SIZE  shift register parallel output
- done_valid  out  1  result available
- done_ready  in  1  result consumer accepts
- done_id  out  1  requester id of the result
- done_data  out  SIZE  result word; equals sr_out while done_valid = 1

## Operation
- States: IDLE, CLEAR, SHIFT, DONE.
- **IDLE**
  - If any req_valid is set, grant exactly one requester. The round-robin pointer names the preferred requester. With only one requester valid, that one wins.
  - The granted requester's req_ready is high in this cycle only.
  - Latch dir, count (saturated to SIZE when larger), pattern, and id.
  - Set the pointer to the other requester. Go to CLEAR.
- **CLEAR**
  - sr_reset_n = 0 for one cycle. Reset the bit index k to 0.
  - Go to SHIFT if count ≠ 0, otherwise go to DONE.
- **SHIFT**
  - Drive sr_enable = 1, sr_direction = latched dir, sr_data_in = pattern[k], then increment k.
  - Leave for DONE after the cycle with k = count−1.
- **DONE**
  - Hold done_valid = 1, done_id = latched id, done_data = sr_out.
  - sr_enable = 0, so the register holds its value.
  - On done_ready = 1, go to IDLE.
- Result mapping:
  - Left: out[count−1−k] = pattern[k], with the bits below fed-in positions being 0.
  - Right: out[SIZE−count+k] = pattern[k], with the remaining bits 0.
  - With count = SIZE: a right shift yields pattern, a left shift yields bit-reversed pattern.
- Requesters hold req_valid and their fields stable until req_ready. req_ready is 0 outside IDLE.
- A dropped req_valid before grant is legal and is simply not granted.
- Reset (asynchronous, any state) drives:
  - state = IDLE, pointer = requester 0, req_ready = 0
  - sr_enable = 0, sr_direction = 0, sr_data_in = 0
  - done_valid = 0, done_id = 0
  - sr_reset_n = 0 while reset is low
- Outside CLEAR and reset, sr_reset_n = 1. Outside SHIFT, sr_enable = 0 and sr_data_in = 0.

## Timing
- Grant happens in IDLE cycle T. CLEAR is T+1. SHIFT covers T+2 … T+count+1. done_valid first rises at T+count+2; for count = 0 it rises at T+2.
- Minimum job period: count+3 cycles, because DONE with immediate done_ready returns to IDLE and the next grant happens in that IDLE cycle.
- Grant and done never occur in the same cycle. There are no back-to-back grants without passing through DONE.
- done_valid stays high indefinitely without done_ready. The next grant is blocked until then, which is the backpressure mechanism.
- All outputs are registered or decoded from state only. req_ready is combinational from state, req_valid and the pointer, with no path from done_ready.

## Structure
- Package shift_sched_pkg:
  - state encoding
  - DIR_LEFT = 0, DIR_RIGHT = 1
  - requester count constant = 2
- Sub-module shift_rr_arbiter: 2-way round-robin arbiter with inputs (req, advance), outputs (grant one-hot, grant_id), and an internal pointer with async active-low reset to 0.
- The shift register is external. The test bench instantiates it on the sr_* pins with the same clk.

## Test plan
- Single right job: req0 with dir = 1, count = 8, pattern = 8'hA5.
  - ready0 pulses once.
  - done_valid at T+10 with done_data = 8'hA5, done_id = 0.
- Single left job: req1 with dir = 0, count = 8, pattern = 8'h01.
  - done_data = 8'h80, done_id = 1.
- Partial and saturated counts:
  - Left, count = 3, pattern = 3'b110 → done_data = 8'h03.
  - Right, count = 3, pattern = 3'b011 → done_data = 8'h60.
  - count = 12 behaves as count = 8.
  - count = 0 → done_data = 8'h00 at T+2.
- Contention: both requesters continuously valid for 4 jobs, done_ready always high.
  - Grant order is 0, 1, 0, 1.
  - Grants are spaced count+3 cycles apart.
- Backpressure: done_ready held low for 5 cycles.
  - done_valid and done_data stay stable.
  - req_ready stays 0 while req0 is pending.
  - The grant happens the cycle after done_ready.
- Reset mid-SHIFT: assert reset at k = 4.
  - Outputs take reset values immediately and the pointer returns to requester 0.
  - After release, a fresh job completes correctly with no residue from the aborted job.

Source files
------------

// File: rtl/shift_sched_pkg.sv
// Shared types and constants for the shift-register job scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shift_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam int NUM_REQ = 2;

endpackage

// File: rtl/shift_rr_arbiter.sv
// Two-way round-robin arbiter; pointer names the preferred requester.
// Latency: grant is combinational from req and the pointer; pointer moves on advance.
// Backpressure: caller gates req; no grant is issued while req is all zero.
module shift_rr_arbiter
    import shift_sched_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_id
);

    logic ptr_q;

    // Prefer the pointed-to requester, otherwise fall back to the other one.
    always_comb begin
        grant    = '0;
        grant_id = ptr_q;
        if (req[ptr_q]) begin
            grant[ptr_q] = 1'b1;
            grant_id     = ptr_q;
        end else if (req[~ptr_q]) begin
            grant[~ptr_q] = 1'b1;
            grant_id      = ~ptr_q;
        end
    end

    // After a grant the loser of this round becomes preferred.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else if (advance) begin
            ptr_q <= ~grant_id;
        end
    end

endmodule

// File: rtl/shift_job_scheduler.sv
// Arbitrates two shift jobs, clears the external shift register, feeds count serial bits, returns the word.
// Latency: grant at T, clear T+1, shift T+2..T+count+1, done_valid from T+count+2.
// Backpressure: done_valid holds until done_ready; no new grant (req_ready=0) until then.
module shift_job_scheduler
    import shift_sched_pkg::*;
#(
    parameter int SIZE  = 8,
    parameter int CNT_W = $clog2(SIZE + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ-1:0]       req_dir,
    input  logic [NUM_REQ*CNT_W-1:0] req_count,
    input  logic [NUM_REQ*SIZE-1:0]  req_pattern,
    output logic                     sr_reset_n,
    output logic                     sr_enable,
    output logic                     sr_direction,
    output logic                     sr_data_in,
    input  logic [SIZE-1:0]          sr_out,
    output logic                     done_valid,
    input  logic                     done_ready,
    output logic                     done_id,
    output logic [SIZE-1:0]          done_data
);

    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

    state_t             state_q, state_d;
    logic               dir_q;
    logic               id_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   k_q;
    logic [SIZE-1:0]    pat_q;

    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] grant;
    logic               grant_id;
    logic               advance;
    logic [CNT_W-1:0]   sel_cnt;
    logic [CNT_W-1:0]   sat_cnt;
    logic [SIZE-1:0]    sel_pat;

    // Requests are only visible to the arbiter in IDLE and out of reset,
    // so req_ready is a pure function of state, req_valid and the pointer.
    assign arb_req   = req_valid & {NUM_REQ{(state_q == ST_IDLE) && reset}};
    assign advance   = |grant;
    assign req_ready = grant;

    shift_rr_arbiter u_arb (
        .clk      (clk),
        .rst_n    (reset),
        .req      (arb_req),
        .advance  (advance),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign sel_cnt = grant_id ? req_count[2*CNT_W-1:CNT_W] : req_count[CNT_W-1:0];
    assign sel_pat = grant_id ? req_pattern[2*SIZE-1:SIZE] : req_pattern[SIZE-1:0];
    // Counts beyond the register width would only push bits off the far end.
    assign sat_cnt = (sel_cnt > CNT_W'(SIZE)) ? CNT_W'(SIZE) : sel_cnt;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: one clear cycle, count shift cycles, then hold in DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (advance) state_d = ST_CLEAR;
            ST_CLEAR: state_d = (cnt_q != '0) ? ST_SHIFT : ST_DONE;
            ST_SHIFT: if (k_q == cnt_q - CNT_W'(1)) state_d = ST_DONE;
            ST_DONE:  if (done_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Job latch at grant and bit index walk during SHIFT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dir_q <= 1'b0;
            id_q  <= 1'b0;
            cnt_q <= '0;
            pat_q <= '0;
            k_q   <= '0;
        end else begin
            if (advance) begin
                dir_q <= req_dir[grant_id];
                id_q  <= grant_id;
                cnt_q <= sat_cnt;
                pat_q <= sel_pat;
            end
            if (state_q == ST_CLEAR) begin
                k_q <= '0;
            end else if (state_q == ST_SHIFT) begin
                k_q <= k_q + CNT_W'(1);
            end
        end
    end

    // Shift-register pins are decoded from state; everything idles low outside SHIFT.
    assign sr_reset_n   = reset && (state_q != ST_CLEAR);
    assign sr_enable    = (state_q == ST_SHIFT);
    assign sr_direction = sr_enable && (dir_q == DIR_RIGHT);
    assign sr_data_in   = sr_enable && pat_q[k_q[IDX_W-1:0]];

    assign done_valid = (state_q == ST_DONE);
    assign done_id    = id_q;
    assign done_data  = sr_out;

endmodule

// File: tb/tb_shift_job_scheduler.sv
module tb_shift_job_scheduler;

    localparam int SIZE  = 8;
    localparam int CNT_W = 4;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [1:0]         req_valid = '0;
    logic [1:0]         req_ready;
    logic [1:0]         req_dir = '0;
    logic [2*CNT_W-1:0] req_count = '0;
    logic [2*SIZE-1:0]  req_pattern = '0;
    logic               sr_reset_n, sr_enable, sr_direction, sr_data_in;
    logic [SIZE-1:0]    sr_q;
    logic               done_valid;
    logic               done_ready = 1'b1;
    logic               done_id;
    logic [SIZE-1:0]    done_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_done_cyc = 0;
    int rdy_cnt [2] = '{0, 0};
    int g_id  [$];
    int g_cyc [$];
    logic [8:0] sb [$];

    shift_job_scheduler #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_dir      (req_dir),
        .req_count    (req_count),
        .req_pattern  (req_pattern),
        .sr_reset_n   (sr_reset_n),
        .sr_enable    (sr_enable),
        .sr_direction (sr_direction),
        .sr_data_in   (sr_data_in),
        .sr_out       (sr_q),
        .done_valid   (done_valid),
        .done_ready   (done_ready),
        .done_id      (done_id),
        .done_data    (done_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External shift register: synchronous clear, shift when enabled.
    always @(posedge clk) begin
        if (!sr_reset_n)     sr_q <= '0;
        else if (sr_enable)  sr_q <= sr_direction ? {sr_data_in, sr_q[SIZE-1:1]}
                                                  : {sr_q[SIZE-2:0], sr_data_in};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] exp_result(input bit id, input bit dir,
                                              input logic [3:0] cnt, input logic [7:0] pat);
        int c;
        logic [7:0] r;
        c = (cnt > 8) ? 8 : int'(cnt);
        r = '0;
        for (int k = 0; k < c; k++) begin
            if (dir) r[SIZE - c + k] = pat[k];
            else     r[c - 1 - k]    = pat[k];
        end
        return {id, r};
    endfunction

    // Grant and completion monitor: grants push expectations, done handshakes pop them.
    always @(negedge clk) begin
        if (reset) begin
            if (req_ready != 2'b00) begin
                check("ready_onehot", $countones(req_ready), 1);
                for (int i = 0; i < 2; i++) begin
                    if (req_ready[i]) begin
                        g_id.push_back(i);
                        g_cyc.push_back(cyc);
                        rdy_cnt[i]++;
                        sb.push_back(exp_result(i[0], req_dir[i], req_count[i*CNT_W +: CNT_W],
                                                req_pattern[i*SIZE +: SIZE]));
                    end
                end
            end
            if (done_valid && done_ready) begin
                last_done_cyc = cyc;
                if (sb.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    logic [8:0] e;
                    e = sb.pop_front();
                    check("done_id", done_id, e[8]);
                    check("done_data", done_data, e[7:0]);
                end
            end
        end
    end

    task automatic set_job(input int id, input bit dir, input logic [3:0] cnt, input logic [7:0] pat);
        req_dir[id] = dir;
        req_count[id*CNT_W +: CNT_W] = cnt;
        req_pattern[id*SIZE +: SIZE] = pat;
    endtask

    task automatic wait_grants(input int n, input int budget);
        int w = 0;
        while (g_id.size() < n && w < budget) begin
            @(posedge clk); #1;
            w++;
        end
        check("grant_wait", g_id.size() >= n, 1);
    endtask

    task automatic wait_drain();
        int w = 0;
        while ((sb.size() != 0 || done_valid) && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        check("drain", sb.size() == 0, 1);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic do_single(input string tag, input int id, input bit dir,
                             input logic [3:0] cnt, input logic [7:0] pat);
        int base, t, sat, r0, w;
        sat  = (cnt > 8) ? 8 : int'(cnt);
        r0   = rdy_cnt[id];
        base = g_id.size();
        set_job(id, dir, cnt, pat);
        req_valid[id] = 1'b1;
        wait_grants(base + 1, 20);
        req_valid[id] = 1'b0;
        if (g_id.size() > base) begin
            check({tag, "_gid"}, g_id[base], id);
            t = g_cyc[base];
            w = 0;
            while (!done_valid && w < 40) begin
                @(negedge clk);
                w++;
            end
            check({tag, "_lat"}, cyc - t, sat + 2);
            wait_drain();
            check({tag, "_rdy_pulses"}, rdy_cnt[id] - r0, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

    initial begin
        int base, w, t;
        logic [8:0] e;

        // Reset values, with requests present to show req_ready is held off.
        req_valid = 2'b11;
        #17;
        check("rst_ready", req_ready, 2'b00);
        check("rst_enable", sr_enable, 0);
        check("rst_srn", sr_reset_n, 0);
        check("rst_dir", sr_direction, 0);
        check("rst_din", sr_data_in, 0);
        check("rst_done_valid", done_valid, 0);
        check("rst_done_id", done_id, 0);
        req_valid = 2'b00;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        check("idle_srn", sr_reset_n, 1);

        // Single jobs, partial and saturated counts.
        do_single("right8",  0, 1'b1, 4'd8,  8'hA5);
        do_single("left8",   1, 1'b0, 4'd8,  8'h01);
        do_single("left3",   0, 1'b0, 4'd3,  8'h06);
        do_single("right3",  1, 1'b1, 4'd3,  8'h03);
        do_single("sat12",   0, 1'b1, 4'd12, 8'h3C);
        do_single("sat12l",  1, 1'b0, 4'd12, 8'h3C);
        do_single("zero",    0, 1'b1, 4'd0,  8'hFF);

        // Contention from a known pointer state.
        pulse_reset();
        set_job(0, 1'b0, 4'd2, 8'h01);
        set_job(1, 1'b1, 4'd2, 8'h02);
        base = g_id.size();
        req_valid = 2'b11;
        wait_grants(base + 4, 60);
        req_valid = 2'b00;
        if (g_id.size() >= base + 4) begin
            for (int i = 0; i < 4; i++) check("rr_order", g_id[base + i], i % 2);
            for (int i = 0; i < 3; i++) check("rr_spacing", g_cyc[base + i + 1] - g_cyc[base + i], 5);
        end
        wait_drain();

        // Backpressure: hold the result, queue a competing request behind it.
        done_ready = 1'b0;
        base = g_id.size();
        set_job(1, 1'b1, 4'd4, 8'h09);
        req_valid[1] = 1'b1;
        wait_grants(base + 1, 20);
        req_valid[1] = 1'b0;
        set_job(0, 1'b0, 4'd1, 8'h01);
        req_valid[0] = 1'b1;
        e = exp_result(1'b1, 1'b1, 4'd4, 8'h09);
        w = 0;
        while (!done_valid && w < 40) begin
            @(negedge clk);
            w++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", done_valid, 1);
            check("bp_data", done_data, e[7:0]);
            check("bp_ready", req_ready, 2'b00);
        end
        @(posedge clk); #1 done_ready = 1'b1;
        wait_grants(base + 2, 20);
        req_valid[0] = 1'b0;
        if (g_id.size() >= base + 2) begin
            check("bp_grant_id", g_id[base + 1], 0);
            check("bp_grant_cyc", g_cyc[base + 1] - last_done_cyc, 1);
        end
        wait_drain();

        // Reset in the middle of a shift at k = 4.
        base = g_id.size();
        set_job(0, 1'b1, 4'd8, 8'hFF);
        req_valid[0] = 1'b1;
        wait_grants(base + 1, 20);
        req_valid[0] = 1'b0;
        if (g_id.size() > base) begin
            t = g_cyc[base];
            w = 0;
            while (cyc != t + 6 && w < 20) begin
                @(negedge clk);
                w++;
            end
            check("mid_enable_before", sr_enable, 1);
            reset = 1'b0;
            sb.delete();
            req_valid = 2'b11;
            set_job(0, 1'b1, 4'd3, 8'h03);
            set_job(1, 1'b0, 4'd8, 8'hFF);
            #1;
            check("mid_enable", sr_enable, 0);
            check("mid_srn", sr_reset_n, 0);
            check("mid_din", sr_data_in, 0);
            check("mid_dir", sr_direction, 0);
            check("mid_done_valid", done_valid, 0);
            check("mid_ready", req_ready, 2'b00);
            repeat (2) @(posedge clk);
            base = g_id.size();
            #1 reset = 1'b1;
            wait_grants(base + 1, 10);
            req_valid = 2'b00;
            if (g_id.size() > base) check("post_rst_ptr", g_id[base], 0);
            wait_drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
